// File: rtl/ctrl_pkg.sv
// Shared definitions for the ctrl_seq instruction sequencer: opcode values,
// ALU operation codes, the one-hot FSM state encoding and the decode bundle
// passed from ctrl_dec to ctrl_seq.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [5:0] {
        ST_FETCH  = 6'b000001,
        ST_DECODE = 6'b000010,
        ST_EXEC   = 6'b000100,
        ST_MEM    = 6'b001000,
        ST_WB     = 6'b010000,
        ST_HALT   = 6'b100000
    } state_t;

    // Static per-instruction controls; br is {beq, bne, blt, bge, bltu, bgeu}.
    typedef struct packed {
        logic       legal;
        logic       is_mem;
        logic       is_store;
        logic       reg_write;
        logic       mux1;
        logic       memtoreg;
        logic       lui;
        logic       u_type;
        logic       jal;
        logic       jalr;
        logic [5:0] br;
        logic [3:0] alu;
    } dec_t;

    // funct3 plus the alternate-op bit to ALU code; alt only matters for ADD/SUB and SRL/SRA.
    function automatic logic [3:0] alu_from_func(input logic [2:0] f, input logic alt);
        logic [3:0] r;
        case (f)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ctrl_dec.sv
// Combinational opcode/funct decode for ctrl_seq. Produces the static control
// bundle for the current instruction; legal=0 sends the sequencer to HALT.
module ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func,
    input  logic       func1,
    output dec_t       dec
);

    // Classify the instruction and derive its datapath controls.
    always_comb begin
        dec     = '0;
        dec.alu = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                dec.legal     = 1'b1;
                dec.reg_write = 1'b1;
                dec.lui       = 1'b1;
                dec.u_type    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.legal     = 1'b1;
                dec.reg_write = 1'b1;
                dec.u_type    = 1'b1;
            end
            OPC_JAL: begin
                dec.legal     = 1'b1;
                dec.reg_write = 1'b1;
                dec.jal       = 1'b1;
            end
            OPC_JALR: begin
                dec.legal     = 1'b1;
                dec.reg_write = 1'b1;
                dec.jalr      = 1'b1;
                dec.mux1      = 1'b1;
            end
            OPC_BRANCH: begin
                case (func)
                    3'b000: begin dec.br = 6'b100000; dec.alu = ALU_SUB;  end
                    3'b001: begin dec.br = 6'b010000; dec.alu = ALU_SUB;  end
                    3'b100: begin dec.br = 6'b001000; dec.alu = ALU_SLT;  end
                    3'b101: begin dec.br = 6'b000100; dec.alu = ALU_SLT;  end
                    3'b110: begin dec.br = 6'b000010; dec.alu = ALU_SLTU; end
                    3'b111: begin dec.br = 6'b000001; dec.alu = ALU_SLTU; end
                    default: dec.br = 6'b000000;
                endcase
                // funct3 010/011 has no branch meaning and is rejected.
                dec.legal = |dec.br;
            end
            OPC_LOAD: begin
                dec.legal     = 1'b1;
                dec.is_mem    = 1'b1;
                dec.reg_write = 1'b1;
                dec.mux1      = 1'b1;
                dec.memtoreg  = 1'b1;
            end
            OPC_STORE: begin
                dec.legal    = 1'b1;
                dec.is_mem   = 1'b1;
                dec.is_store = 1'b1;
                dec.mux1     = 1'b1;
            end
            OPC_IMM: begin
                dec.legal     = 1'b1;
                dec.reg_write = 1'b1;
                dec.mux1      = 1'b1;
                // Immediate forms have no SUB; bit 30 only selects SRAI.
                dec.alu       = alu_from_func(func, (func == 3'b101) && func1);
            end
            OPC_OP: begin
                dec.legal     = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu       = alu_from_func(func, func1);
            end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Outputs are decoded from the registered state plus the held instruction
// fields; only ir_en looks at imem_ready combinationally.
// Optional build macro: CTRL_PERF_CNT_EN adds the instret retire counter.
//
//   state  | meaning
//   FETCH  | wait for imem_ready, latch instruction (ir_en)
//   DECODE | classify opcode; illegal goes to HALT
//   EXEC   | ALU cycle, branch strobes valid
//   MEM    | hold dmem_req until dmem_ready
//   WB     | retire: pc_en, reg_write
//   HALT   | illegal instruction seen; left only by reset
module ctrl_seq
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func,
    input  logic        func1,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        ir_en,
    output logic        pc_en,
    output logic        mux1,
    output logic        memtoreg,
    output logic        reg_write,
    output logic        lui,
    output logic        U_type,
    output logic        beq,
    output logic        bne,
    output logic        blt,
    output logic        bge,
    output logic        bltu,
    output logic        bgeu,
    output logic        jal,
    output logic        jalr,
    output logic [3:0]  alu_order,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        illegal
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] instret
`endif
);

    state_t state;
    state_t state_nxt;
    dec_t   dec;
    logic   in_instr;
    logic   br_phase;

    ctrl_dec u_dec (
        .opcode (opcode),
        .func   (func),
        .func1  (func1),
        .dec    (dec)
    );

    assign in_instr = (state == ST_DECODE) || (state == ST_EXEC) ||
                      (state == ST_MEM)    || (state == ST_WB);
    assign br_phase = (state == ST_EXEC) || (state == ST_WB);

    // State register; reset returns to FETCH so fetching resumes right after release.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_FETCH;
        else       state <= state_nxt;
    end

    // Next state and state-decoded controls; every output is held low during reset.
    always_comb begin
        state_nxt = state;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        mux1      = 1'b0;
        memtoreg  = 1'b0;
        reg_write = 1'b0;
        lui       = 1'b0;
        U_type    = 1'b0;
        jal       = 1'b0;
        jalr      = 1'b0;
        alu_order = ALU_ADD;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        illegal   = 1'b0;
        {beq, bne, blt, bge, bltu, bgeu} = 6'b000000;
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        ir_en     = 1'b1;
                        state_nxt = ST_DECODE;
                    end
                end
                ST_DECODE: state_nxt = dec.legal ? ST_EXEC : ST_HALT;
                ST_EXEC:   state_nxt = dec.is_mem ? ST_MEM : ST_WB;
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = dec.is_store;
                    if (dmem_ready) state_nxt = ST_WB;
                end
                ST_WB: begin
                    pc_en     = 1'b1;
                    reg_write = dec.reg_write;
                    state_nxt = ST_FETCH;
                end
                ST_HALT:   illegal   = 1'b1;
                default:   state_nxt = ST_FETCH;
            endcase
            if (in_instr) begin
                mux1      = dec.mux1;
                memtoreg  = dec.memtoreg;
                alu_order = dec.alu;
                lui       = dec.lui;
                U_type    = dec.u_type;
                jal       = dec.jal;
                jalr      = dec.jalr;
            end
            if (br_phase) {beq, bne, blt, bge, bltu, bgeu} = dec.br;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret_q;

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset)      instret_q <= '0;
        else if (pc_en) instret_q <= instret_q + 32'd1;
    end

    assign instret = reset ? 32'd0 : instret_q;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: stimulus pushes the expected retire record,
// a monitor pops and compares on every pc_en. Build with CTRL_PERF_CNT_EN
// defined to also exercise the instret counter.
module tb_ctrl_seq;

    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_IMM    = 7'b0010011;
    localparam logic [6:0] T_OP     = 7'b0110011;

    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_SLT  = 4'd3;
    localparam logic [3:0] A_SLTU = 4'd4;
    localparam logic [3:0] A_SRA  = 4'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  func = '0;
    logic        func1 = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        ir_en, pc_en, mux1, memtoreg, reg_write, lui, U_type;
    logic        beq, bne, blt, bge, bltu, bgeu, jal, jalr;
    logic [3:0]  alu_order;
    logic        dmem_req, dmem_we, illegal;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret;
`endif

    ctrl_seq dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .func       (func),
        .func1      (func1),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .ir_en      (ir_en),
        .pc_en      (pc_en),
        .mux1       (mux1),
        .memtoreg   (memtoreg),
        .reg_write  (reg_write),
        .lui        (lui),
        .U_type     (U_type),
        .beq        (beq),
        .bne        (bne),
        .blt        (blt),
        .bge        (bge),
        .bltu       (bltu),
        .bgeu       (bgeu),
        .jal        (jal),
        .jalr       (jalr),
        .alu_order  (alu_order),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .illegal    (illegal)
`ifdef CTRL_PERF_CNT_EN
        ,
        .instret    (instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        int         req_n;
        int         we_n;
        int         br_cyc;
        logic       rw;
        logic       mux1;
        logic       memtoreg;
        logic       alu_chk;
        logic       jal;
        logic       jalr;
        logic       lui;
        logic       ut;
        logic [3:0] alu;
        logic [5:0] br;
    } exp_t;

    exp_t expq [$];
    int   checks = 0;
    int   failures = 0;
    int   idle_pre = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [21:0] outs();
        return {ir_en, pc_en, mux1, memtoreg, reg_write, lui, U_type,
                beq, bne, blt, bge, bltu, bgeu, jal, jalr, alu_order,
                dmem_req, dmem_we, illegal};
    endfunction

    // ALU code from mnemonic order: ADD SLL SLT SLTU XOR SRL OR AND, alt gives SUB/SRA.
    function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt);
        logic [3:0] tbl [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        logic [3:0] r;
        r = tbl[f];
        if (alt && f == 3'd0) r = A_SUB;
        if (alt && f == 3'd5) r = A_SRA;
        return r;
    endfunction

    // Expected retire record from the instruction rules and the ready delays.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f, input logic f1,
                                   input int di, input int dm);
        exp_t e;
        int   bpos [8] = '{5, 4, 0, 0, 3, 2, 1, 0};
        bit   mem;
        mem        = (op == T_LOAD) || (op == T_STORE);
        e.lat      = di + 4 + (mem ? dm + 1 : 0);
        e.req_n    = mem ? dm + 1 : 0;
        e.we_n     = (op == T_STORE) ? dm + 1 : 0;
        e.rw       = !(op == T_BRANCH || op == T_STORE);
        e.mux1     = (op == T_IMM) || (op == T_LOAD) || (op == T_STORE) || (op == T_JALR);
        e.memtoreg = (op == T_LOAD);
        e.lui      = (op == T_LUI);
        e.ut       = (op == T_LUI) || (op == T_AUIPC);
        e.jal      = (op == T_JAL);
        e.jalr     = (op == T_JALR);
        e.alu_chk  = 1'b1;
        e.alu      = A_ADD;
        e.br       = 6'b000000;
        e.br_cyc   = 0;
        case (op)
            T_OP:  e.alu = alu_of(f, f1);
            T_IMM: e.alu = alu_of(f, (f == 3'd5) && f1);
            T_BRANCH: begin
                e.br     = 6'b000001 << bpos[f];
                e.br_cyc = 2;
                e.alu    = (f[2] == 1'b0) ? A_SUB : (f[1] ? A_SLTU : A_SLT);
            end
            T_LUI, T_AUIPC, T_JAL: e.alu_chk = 1'b0;
            default: ;
        endcase
        return e;
    endfunction

    // Drive one instruction starting in a FETCH cycle; returns in the next FETCH cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f, input logic f1,
                             input int di, input int dm);
        bit done = 0;
        bit mem;
        expq.push_back(model(op, f, f1, di + idle_pre, dm));
        idle_pre = 0;
        mem    = (op == T_LOAD) || (op == T_STORE);
        opcode = op;
        func   = f;
        func1  = f1;
        for (int k = 0; k < 64 && !done; k++) begin
            if (k < di)       imem_ready = 1'b0;
            else if (k == di) imem_ready = 1'b1;
            else              imem_ready = 1'($urandom_range(0, 1));
            if (mem && k >= di + 3 && k < di + 3 + dm) dmem_ready = 1'b0;
            else if (mem && k == di + 3 + dm)          dmem_ready = 1'b1;
            else                                       dmem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (k == di) chk("ir_en_accept", 32'(ir_en), 32'd1);
            if (pc_en) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("retire_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'd0);
`ifdef CTRL_PERF_CNT_EN
        chk("reset_instret", instret, 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: accumulate per-instruction observations, compare on each retire.
    initial begin : monitor
        int         cnt, req_n, we_n, rw_early, br_cyc, br_multi, ir_n;
        logic [5:0] brv;
        exp_t       e;
        cnt = 0; req_n = 0; we_n = 0; rw_early = 0; br_cyc = 0; br_multi = 0; ir_n = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0; req_n = 0; we_n = 0; rw_early = 0; br_cyc = 0; br_multi = 0; ir_n = 0;
            end else begin
                cnt++;
                brv = {beq, bne, blt, bge, bltu, bgeu};
                if (dmem_req) req_n++;
                if (dmem_we) we_n++;
                if (reg_write && !pc_en) rw_early++;
                if (ir_en) ir_n++;
                if (brv != 6'b0) br_cyc++;
                if ($countones(brv) > 1) br_multi++;
                if (pc_en) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("latency", 32'(cnt), 32'(e.lat));
                        chk("reg_write_wb", 32'(reg_write), 32'(e.rw));
                        chk("reg_write_early", 32'(rw_early), 32'd0);
                        if (e.alu_chk) chk("alu_order", 32'(alu_order), 32'(e.alu));
                        chk("mux1", 32'(mux1), 32'(e.mux1));
                        chk("memtoreg", 32'(memtoreg), 32'(e.memtoreg));
                        chk("branch_strobe", 32'(brv), 32'(e.br));
                        chk("branch_cycles", 32'(br_cyc), 32'(e.br_cyc));
                        chk("branch_onehot", 32'(br_multi), 32'd0);
                        chk("jump_utype", 32'({jal, jalr, lui, U_type}),
                            32'({e.jal, e.jalr, e.lui, e.ut}));
                        chk("dmem_req_cycles", 32'(req_n), 32'(e.req_n));
                        chk("dmem_we_cycles", 32'(we_n), 32'(e.we_n));
                        chk("ir_en_count", 32'(ir_n), 32'd1);
                    end
                    cnt = 0; req_n = 0; we_n = 0; rw_early = 0; br_cyc = 0; br_multi = 0; ir_n = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [6:0] ops [9];
        logic [6:0] op;
        logic [2:0] f;
        bit         seen;
        int         pc_n, ill_n;
        ops = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH, T_LOAD, T_STORE, T_IMM, T_OP};

        do_reset();
        // SUB right after reset release, ready high.
        run_instr(T_OP, 3'b000, 1'b1, 0, 0);
        // LOAD with three dmem wait cycles.
        run_instr(T_LOAD, 3'b010, 1'b0, 0, 3);
        // BLTU.
        run_instr(T_BRANCH, 3'b110, 1'b0, 0, 0);
        run_instr(T_IMM, 3'b101, 1'b1, 1, 0);
        run_instr(T_IMM, 3'b000, 1'b1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 8)];
            f  = 3'($urandom_range(0, 7));
            while (op == T_BRANCH && (f == 3'd2 || f == 3'd3)) f = 3'($urandom_range(0, 7));
            run_instr(op, f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));
        end

        // Reset during a STORE's MEM wait aborts with no retire.
        opcode = T_STORE; func = 3'b010; func1 = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (dmem_req) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("abort_reached_mem", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 32'(outs()), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b0;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("abort_refetch", 32'({ir_en, dmem_req}), 32'd2);
        @(posedge clk);
        #1;

        // Illegal opcode halts.
        do_reset();
        opcode = 7'b1111111; func = 3'b000; func1 = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("illegal_cycle1", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("illegal_cycle2", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("illegal_cycle3", 32'(illegal), 32'd1);
        pc_n = 0;
        ill_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (pc_en) pc_n++;
            if (illegal) ill_n++;
        end
        chk("halt_no_pc_en", 32'(pc_n), 32'd0);
        chk("halt_sticky", 32'(ill_n), 32'd20);
        chk("halt_strobes", 32'(outs() & 22'h3FFFFE), 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("illegal_cleared", 32'(illegal), 32'd0);

        // Branch funct3 010 is illegal.
        @(posedge clk);
        #1;
        do_reset();
        opcode = T_BRANCH; func = 3'b010; imem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("illegal_branch_func", 32'({illegal, pc_en}), 32'd2);
        @(posedge clk);
        #1;

`ifdef CTRL_PERF_CNT_EN
        do_reset();
        for (int n = 0; n < 10; n++)
            run_instr(T_IMM, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, 0);
        imem_ready = 1'b0;
        @(negedge clk);
        chk("instret_ten", instret, 32'd10);
        force dut.instret_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut.instret_q;
        idle_pre = 1;
        run_instr(T_IMM, 3'b000, 1'b0, 0, 0);
        @(negedge clk);
        chk("instret_wrap", instret, 32'd0);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
